// File: rtl/icache_mem_responder.sv
// Memory-side responder for the icache fetch channel: forwards refill requests to the
// shared RAM port, yields to the data side, and returns a safe word on RAM error or timeout.
module icache_mem_responder #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iREN_i,
    input  logic [31:0] iaddr_i,
    output logic        iwait_o,
    output logic [31:0] iload_o,
    input  logic        dbusy_i,
    output logic        ramREN_o,
    output logic [31:0] ramaddr_o,
    input  logic [31:0] ramload_i,
    input  logic [1:0]  ramstate_i,
    output logic        ierr_o
);

    localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [31:0]    addr_q;
    logic [31:0]    iload_q;
    logic [CW-1:0]  cnt_q;
    logic           iwait_q;
    logic           ierr_q;

    logic           addrChange_d;
    logic           ramAccess_d;
    logic           ramFault_d;

    always_comb begin
        addrChange_d = (iaddr_i != addr_q);
        ramAccess_d  = (ramstate_i == RAM_ACCESS);
        ramFault_d   = (ramstate_i == RAM_ERROR) || (cnt_q == CNT_MAX);
    end

    // Priority inside REQ: abort, then redirect, then data, then error/timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            iload_q <= '0;
            cnt_q   <= '0;
            iwait_q <= 1'b1;
            ierr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    iwait_q <= 1'b1;
                    if (iREN_i && !dbusy_i) begin
                        addr_q  <= iaddr_i;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!iREN_i) begin
                        state_q <= IDLE;
                    end else if (addrChange_d) begin
                        addr_q <= iaddr_i;
                        cnt_q  <= '0;
                    end else if (ramAccess_d) begin
                        iload_q <= ramload_i;
                        iwait_q <= 1'b0;
                        state_q <= RESP;
                    end else if (ramFault_d) begin
                        iload_q <= ERR_WORD;
                        ierr_q  <= 1'b1;
                        iwait_q <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    iwait_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    iwait_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The data side steals the RAM port within the same cycle, so this gate stays combinational.
    assign ramREN_o  = (state_q == REQ) && !dbusy_i;
    assign ramaddr_o = addr_q;
    assign iwait_o   = iwait_q;
    assign iload_o   = iload_q;
    assign ierr_o    = ierr_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Scoreboard bench for icache_mem_responder: expected words are queued as stimulus is
// driven and popped when iwait drops; TIMEOUT is shortened to 8.
module tb_icache_mem_responder;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        clk;
    logic        rst;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dbusy;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ierr;

    int checks = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    icache_mem_responder #(.TIMEOUT(8), .ERR_WORD(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst), .iREN_i(iREN), .iaddr_i(iaddr),
        .iwait_o(iwait), .iload_o(iload), .dbusy_i(dbusy),
        .ramREN_o(ramREN), .ramaddr_o(ramaddr), .ramload_i(ramload),
        .ramstate_i(ramstate), .ierr_o(ierr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iREN = 1'b0; iaddr = '0; dbusy = 1'b0; ramload = '0; ramstate = FREE;
        tick();
        tick();
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL reset_iwait: got %b expected 1", iwait); end
        checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL reset_ramREN: got %b expected 0", ramREN); end
        checks++; if (iload !== 32'h0) begin failures++; $display("[TB] FAIL reset_iload: got %h expected 0", iload); end
        checks++; if (ierr !== 1'b0) begin failures++; $display("[TB] FAIL reset_ierr: got %b expected 0", ierr); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("[TB] FAIL reset_ramaddr: got %h expected 0", ramaddr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        logic [31:0] exp;
        iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h8C22_0004;
        expQ.push_back(32'h8C22_0004);
        tick();
        checks++; if (ramREN !== 1'b1) begin failures++; $display("[TB] FAIL hit_ramREN: got %b expected 1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin failures++; $display("[TB] FAIL hit_ramaddr: got %h expected 00000040", ramaddr); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL hit_iwait_req: got %b expected 1", iwait); end
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL hit_iwait_resp: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL hit_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL hit_iload: got %h expected %h", iload, exp); end
        end
        iREN = 1'b0; ramstate = FREE;
        tick();
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL hit_iwait_after: got %b expected 1", iwait); end
        checks++; if (iload !== 32'h8C22_0004) begin failures++; $display("[TB] FAIL hit_iload_hold: got %h expected 8c220004", iload); end
    endtask

    task automatic test_slow_ram();
        logic [31:0] exp;
        int renCount = 0;
        int earlyLow = 0;
        iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY; ramload = 32'h1234_5678;
        expQ.push_back(32'h1234_5678);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (ramREN === 1'b1) renCount++;
            if (iwait !== 1'b1) earlyLow++;
            if (c == 4) ramstate = ACCESS;
        end
        tick();
        checks++; if (renCount != 4) begin failures++; $display("[TB] FAIL slow_ren_cycles: got %0d expected 4", renCount); end
        checks++; if (earlyLow != 0) begin failures++; $display("[TB] FAIL slow_early_resp: got %0d expected 0", earlyLow); end
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL slow_iwait_resp: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL slow_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL slow_iload: got %h expected %h", iload, exp); end
        end
        iREN = 1'b0; ramstate = FREE;
        tick();
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL slow_iwait_after: got %b expected 1", iwait); end
    endtask

    task automatic test_arbitration();
        logic [31:0] exp;
        iREN = 1'b1; dbusy = 1'b1; iaddr = 32'h200; ramstate = ACCESS; ramload = 32'hA5A5_0001;
        expQ.push_back(32'hA5A5_0001);
        tick();
        checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL arb_ramREN_busy: got %b expected 0", ramREN); end
        checks++; if (ramaddr !== 32'h100) begin failures++; $display("[TB] FAIL arb_ramaddr_busy: got %h expected 00000100", ramaddr); end
        dbusy = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL arb_still_idle: got %b expected 0", ramREN); end
        tick();
        checks++; if (ramREN !== 1'b1) begin failures++; $display("[TB] FAIL arb_ramREN_req: got %b expected 1", ramREN); end
        checks++; if (ramaddr !== 32'h200) begin failures++; $display("[TB] FAIL arb_ramaddr_req: got %h expected 00000200", ramaddr); end
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL arb_iwait_resp: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL arb_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL arb_iload: got %h expected %h", iload, exp); end
        end
        iREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        int earlyLow = 0;
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hCAFE_0080;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (iwait !== 1'b1) earlyLow++;
        end
        checks++; if (ramaddr !== 32'h40) begin failures++; $display("[TB] FAIL redir_ramaddr_before: got %h expected 00000040", ramaddr); end
        iaddr = 32'h80;
        expQ.push_back(32'hCAFE_0080);
        tick();
        checks++; if (ramaddr !== 32'h80) begin failures++; $display("[TB] FAIL redir_ramaddr_after: got %h expected 00000080", ramaddr); end
        checks++; if (ramREN !== 1'b1) begin failures++; $display("[TB] FAIL redir_ramREN: got %b expected 1", ramREN); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (iwait !== 1'b1) earlyLow++;
        end
        checks++; if (earlyLow != 0) begin failures++; $display("[TB] FAIL redir_cnt_reset: got %0d early responses expected 0", earlyLow); end
        ramstate = ACCESS;
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL redir_iwait_resp: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL redir_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL redir_iload: got %h expected %h", iload, exp); end
        end
        checks++; if (ierr !== 1'b0) begin failures++; $display("[TB] FAIL redir_ierr: got %b expected 0", ierr); end
        iREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    task automatic test_abort();
        int lowSeen = 0;
        iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY; ramload = 32'h5555_AAAA;
        tick();
        tick();
        iREN = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("[TB] FAIL abort_ramREN_req: got %b expected 1", ramREN); end
        tick();
        checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL abort_ramREN_idle: got %b expected 0", ramREN); end
        if (iwait !== 1'b1) lowSeen++;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (iwait !== 1'b1) lowSeen++;
        end
        checks++; if (lowSeen != 0) begin failures++; $display("[TB] FAIL abort_no_resp: got %0d pulses expected 0", lowSeen); end
        checks++; if (iload !== 32'hCAFE_0080) begin failures++; $display("[TB] FAIL abort_iload_hold: got %h expected cafe0080", iload); end
        checks++; if (ramaddr !== 32'h300) begin failures++; $display("[TB] FAIL abort_ramaddr_hold: got %h expected 00000300", ramaddr); end
        ramstate = FREE;
    endtask

    task automatic test_error();
        logic [31:0] exp;
        iREN = 1'b1; iaddr = 32'h400; ramstate = ERROR; ramload = 32'hDEAD_BEEF;
        expQ.push_back(32'h0000_0000);
        tick();
        checks++; if (ierr !== 1'b0) begin failures++; $display("[TB] FAIL err_ierr_req: got %b expected 0", ierr); end
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL err_iwait_resp: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL err_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL err_iload: got %h expected %h", iload, exp); end
        end
        checks++; if (ierr !== 1'b1) begin failures++; $display("[TB] FAIL err_ierr_set: got %b expected 1", ierr); end
        iREN = 1'b0; ramstate = FREE;
        tick();
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL err_iwait_after: got %b expected 1", iwait); end
        checks++; if (ierr !== 1'b1) begin failures++; $display("[TB] FAIL err_ierr_sticky: got %b expected 1", ierr); end
    endtask

    task automatic test_timeout();
        logic [31:0] exp;
        int respAt = 0;
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY; ramload = 32'h1111_1111;
        expQ.push_back(32'h0000_0000);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (iwait === 1'b0) begin
                respAt = c;
                break;
            end
            if (c == 3) begin
                dbusy = 1'b1;
                #1;
                checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL tmo_dbusy_ramREN: got %b expected 0", ramREN); end
            end
            if (c == 4) dbusy = 1'b0;
        end
        checks++; if (respAt != 9) begin failures++; $display("[TB] FAIL tmo_latency: got %0d expected 9", respAt); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL tmo_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL tmo_iload: got %h expected %h", iload, exp); end
        end
        checks++; if (ierr !== 1'b1) begin failures++; $display("[TB] FAIL tmo_ierr: got %b expected 1", ierr); end
        iREN = 1'b0; ramstate = FREE; dbusy = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        iREN = 1'b1; iaddr = 32'h600; ramstate = ACCESS; ramload = 32'h0BAD_0600;
        expQ.push_back(32'h0BAD_0600);
        tick();
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_iwait: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL b2b_first_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL b2b_first_iload: got %h expected %h", iload, exp); end
        end
        iaddr = 32'h604; ramload = 32'h0BAD_0604;
        expQ.push_back(32'h0BAD_0604);
        tick();
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle_iwait: got %b expected 1", iwait); end
        tick();
        checks++; if (ramaddr !== 32'h604) begin failures++; $display("[TB] FAIL b2b_ramaddr: got %h expected 00000604", ramaddr); end
        checks++; if (ramREN !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ramREN: got %b expected 1", ramREN); end
        tick();
        checks++; if (iwait !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_iwait: got %b expected 0", iwait); end
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL b2b_second_scoreboard: got empty queue expected one entry"); end
        else begin
            exp = expQ.pop_front();
            if (iload !== exp) begin failures++; $display("[TB] FAIL b2b_second_iload: got %h expected %h", iload, exp); end
        end
        iREN = 1'b0; ramstate = FREE;
        tick();
        checks++; if (ierr !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ierr_sticky: got %b expected 1", ierr); end
    endtask

    task automatic test_reset_midflight();
        iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY; ramload = 32'h7777_7777;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ramREN: got %b expected 0", ramREN); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_ramaddr: got %h expected 0", ramaddr); end
        checks++; if (iload !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_iload: got %h expected 0", iload); end
        checks++; if (ierr !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ierr: got %b expected 0", ierr); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_iwait: got %b expected 1", iwait); end
        iREN = 1'b0; ramstate = FREE;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_slow_ram();
        test_arbitration();
        test_redirect();
        test_abort();
        test_error();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
